// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32x32 array with byte-enable writes and a
// same-cycle write-to-read bypass on both read ports.

module wb_regfile_rdport (
  input  logic [4:0]  addr,
  input  logic [31:0] arr,
  input  logic        bypass_en,
  input  logic [4:0]  wr_rd,
  input  logic [31:0] merged,
  output logic [31:0] data
);
  // R0 wins over the bypass; bypass_en already excludes Rd=0 and reset.
  assign data = (addr == 5'd0)                   ? 32'd0  :
                (bypass_en && (addr == wr_rd))   ? merged : arr;
endmodule

module wb_regfile (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] ALUShift_out_in,
  input  logic [31:0] Data_in,
  input  logic [3:0]  Rd_write_by_en_in,
  input  logic        Overflow_in,
  input  logic        RegWr_in,
  input  logic        MemtoReg_in,
  input  logic [4:0]  Rd_in,
  input  logic [4:0]  Rs_addr,
  input  logic [4:0]  Rt_addr,
  output logic [31:0] busA,
  output logic [31:0] busB,
  output logic [31:0] WB_data,
  output logic        WB_we,
  output logic [4:0]  WB_rd
);
  localparam int NUM_PORTS = 2;
  localparam int NUM_BYTES = 4;

  logic [31:0][31:0]           regs;
  logic [31:0]                 cur;
  logic [31:0]                 merged;
  logic [NUM_PORTS-1:0][4:0]   rd_addr;
  logic [NUM_PORTS-1:0][31:0]  rd_data;

  assign WB_data = MemtoReg_in ? Data_in : ALUShift_out_in;
  assign WB_we   = !Reset && RegWr_in && !Overflow_in &&
                   (Rd_in != 5'd0) && (Rd_write_by_en_in != 4'd0);
  assign WB_rd   = Rd_in;

  // Byte-merged image of the destination, shared by the write path and bypass.
  assign cur = regs[Rd_in];
  for (genvar b = 0; b < NUM_BYTES; b++) begin : g_byte
    assign merged[8*b +: 8] = Rd_write_by_en_in[b] ? WB_data[8*b +: 8] : cur[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (Reset)
      regs <= '0;
    else if (WB_we)
      regs[Rd_in] <= merged;
  end

  assign rd_addr = {Rt_addr, Rs_addr};
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    wb_regfile_rdport u_port (
      .addr      (rd_addr[p]),
      .arr       (regs[rd_addr[p]]),
      .bypass_en (WB_we),
      .wr_rd     (Rd_in),
      .merged    (merged),
      .data      (rd_data[p])
    );
  end

  assign busA = rd_data[0];
  assign busB = rd_data[1];
endmodule

// File: tb/tb_wb_regfile.sv
// Table-driven bench for wb_regfile; expected outputs go through a scoreboard
// queue and are checked mid-cycle, before the write edge.

module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] ALUShift_out_in, Data_in;
  logic [3:0]  Rd_write_by_en_in;
  logic        Overflow_in, RegWr_in, MemtoReg_in;
  logic [4:0]  Rd_in, Rs_addr, Rt_addr;
  logic [31:0] busA, busB, WB_data;
  logic        WB_we;
  logic [4:0]  WB_rd;

  int n_tests = 0;
  int n_fail  = 0;

  wb_regfile dut (
    .clk(clk), .Reset(Reset), .ALUShift_out_in(ALUShift_out_in), .Data_in(Data_in),
    .Rd_write_by_en_in(Rd_write_by_en_in), .Overflow_in(Overflow_in),
    .RegWr_in(RegWr_in), .MemtoReg_in(MemtoReg_in), .Rd_in(Rd_in),
    .Rs_addr(Rs_addr), .Rt_addr(Rt_addr), .busA(busA), .busB(busB),
    .WB_data(WB_data), .WB_we(WB_we), .WB_rd(WB_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, regwr, m2r, ovf;
    logic [3:0]  en;
    logic [4:0]  rd, rs, rt;
    logic [31:0] alu, data;
    logic        x_we;
    logic [31:0] x_wbd, x_a, x_b;
  } vec_t;

  typedef struct {
    string       tag;
    logic        we;
    logic [31:0] wbd, a, b;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[16];

  function automatic vec_t mk(logic rst, logic regwr, logic m2r, logic ovf, logic [3:0] en,
                              logic [4:0] rd, logic [4:0] rs, logic [4:0] rt,
                              logic [31:0] alu, logic [31:0] data,
                              logic x_we, logic [31:0] x_a, logic [31:0] x_b);
    vec_t v;
    v.rst = rst; v.regwr = regwr; v.m2r = m2r; v.ovf = ovf; v.en = en;
    v.rd = rd; v.rs = rs; v.rt = rt; v.alu = alu; v.data = data;
    v.x_we = x_we; v.x_a = x_a; v.x_b = x_b;
    v.x_wbd = m2r ? data : alu;
    return v;
  endfunction

  task automatic chk32(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Drive on the falling edge, check 2ns later, let the next rising edge write.
  task automatic apply(string tag, vec_t v);
    exp_t e, g;
    @(negedge clk);
    Reset = v.rst; RegWr_in = v.regwr; MemtoReg_in = v.m2r; Overflow_in = v.ovf;
    Rd_write_by_en_in = v.en; Rd_in = v.rd; Rs_addr = v.rs; Rt_addr = v.rt;
    ALUShift_out_in = v.alu; Data_in = v.data;
    e.tag = tag; e.we = v.x_we; e.wbd = v.x_wbd; e.a = v.x_a; e.b = v.x_b; e.rd = v.rd;
    sb.push_back(e);
    #2;
    g = sb.pop_front();
    chk32({g.tag, ".WB_we"},   {31'd0, WB_we}, {31'd0, g.we});
    chk32({g.tag, ".WB_data"}, WB_data, g.wbd);
    chk32({g.tag, ".WB_rd"},   {27'd0, WB_rd}, {27'd0, g.rd});
    chk32({g.tag, ".busA"},    busA, g.a);
    chk32({g.tag, ".busB"},    busB, g.b);
  endtask

  initial begin
    vec_t rd_v;
    Reset = 1'b1; RegWr_in = 0; MemtoReg_in = 0; Overflow_in = 0;
    Rd_write_by_en_in = 0; Rd_in = 0; Rs_addr = 0; Rt_addr = 0;
    ALUShift_out_in = 0; Data_in = 0;

    //          rst rw m2r ovf en     rd  rs  rt  alu           data          we  busA          busB
    vecs[0]  = mk(0, 1, 0, 0, 4'hF,  5,  5,  0, 32'hDEADBEEF, 32'h0,        1, 32'hDEADBEEF, 32'h0);
    vecs[1]  = mk(0, 0, 0, 0, 4'h0,  5,  5,  5, 32'h0,        32'h0,        0, 32'hDEADBEEF, 32'hDEADBEEF);
    vecs[2]  = mk(0, 1, 1, 0, 4'h3,  5,  5,  5, 32'h0,        32'h11223344, 1, 32'hDEAD3344, 32'hDEAD3344);
    vecs[3]  = mk(0, 0, 0, 0, 4'h0,  1,  5,  0, 32'h0,        32'h0,        0, 32'hDEAD3344, 32'h0);
    vecs[4]  = mk(0, 1, 0, 1, 4'hF,  7,  7,  7, 32'h7FFFFFFF, 32'h0,        0, 32'h0,        32'h0);
    vecs[5]  = mk(0, 0, 0, 0, 4'h0,  1,  7,  5, 32'h0,        32'h0,        0, 32'h0,        32'hDEAD3344);
    vecs[6]  = mk(0, 1, 0, 0, 4'hF,  0,  0,  0, 32'hFFFFFFFF, 32'h0,        0, 32'h0,        32'h0);
    vecs[7]  = mk(0, 0, 0, 0, 4'h0,  1,  0,  5, 32'h0,        32'h0,        0, 32'h0,        32'hDEAD3344);
    vecs[8]  = mk(0, 1, 0, 0, 4'h0,  5,  5,  0, 32'hAAAAAAAA, 32'h0,        0, 32'hDEAD3344, 32'h0);
    vecs[9]  = mk(0, 1, 0, 0, 4'h8,  6,  6,  5, 32'hA5FFFFFF, 32'h0,        1, 32'hA5000000, 32'hDEAD3344);
    vecs[10] = mk(0, 1, 1, 0, 4'h4,  6,  5,  6, 32'h0,        32'h00BB1122, 1, 32'hDEAD3344, 32'hA5BB0000);
    vecs[11] = mk(0, 0, 0, 0, 4'h0,  1,  6,  5, 32'h0,        32'h0,        0, 32'hA5BB0000, 32'hDEAD3344);
    vecs[12] = mk(1, 1, 0, 0, 4'hF,  9,  9,  5, 32'h12345678, 32'h0,        0, 32'h0,        32'hDEAD3344);
    vecs[13] = mk(0, 0, 0, 0, 4'h0,  1,  9,  5, 32'h0,        32'h0,        0, 32'h0,        32'h0);
    vecs[14] = mk(0, 1, 0, 0, 4'hF,  9,  9,  9, 32'hCAFEF00D, 32'h0,        1, 32'hCAFEF00D, 32'hCAFEF00D);
    vecs[15] = mk(0, 0, 0, 0, 4'h0,  1,  9,  6, 32'h0,        32'h0,        0, 32'hCAFEF00D, 32'h0);

    // One-edge reset pulse, then every address reads zero on both ports.
    @(negedge clk); Reset = 1'b1;
    @(negedge clk); Reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_v = mk(0, 0, 0, 0, 4'h0, 5'd1, 5'(i), 5'(31 - i), 32'h0, 32'h0, 0, 32'h0, 32'h0);
      apply($sformatf("rst_read%0d", i), rd_v);
    end

    for (int i = 0; i < 16; i++)
      apply($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back byte writes to one register: each cycle's bypass must
    // merge with the value written on the previous edge.
    apply("b2b0", mk(0, 1, 0, 0, 4'h1, 12, 12, 0, 32'h000000AA, 32'h0, 1, 32'h000000AA, 32'h0));
    apply("b2b1", mk(0, 1, 0, 0, 4'h2, 12, 12, 12, 32'h0000BB00, 32'h0, 1, 32'h0000BBAA, 32'h0000BBAA));
    apply("b2b2", mk(0, 0, 0, 0, 4'h0, 1, 12, 0, 32'h0, 32'h0, 0, 32'h0000BBAA, 32'h0));

    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: pipeline clock; the register array updates on the rising edge, half a cycle after the MEM/WB register's falling-edge latch.
REQ-002 The block SHALL have the port Reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have the port ALUShift_out_in, input, 32 bits: ALU/shifter result from MEM/WB.
REQ-004 The block SHALL have the port Data_in, input, 32 bits: load data from MEM/WB.
REQ-005 The block SHALL have the port Rd_write_by_en_in, input, 4 bits: byte write enables; bit i controls byte bits [8i+7:8i].
REQ-006 The block SHALL have the port Overflow_in, input, 1 bit: arithmetic overflow flag from MEM/WB.
REQ-007 The block SHALL have the ports RegWr_in and MemtoReg_in, input, 1 bit each: register-write request and writeback source select.
REQ-008 The block SHALL have the port Rd_in, input, 5 bits: destination register number.
REQ-009 The block SHALL have the ports Rs_addr and Rt_addr, input, 5 bits each: read addresses from the decode stage.
REQ-010 The block SHALL have the ports busA and busB, output, 32 bits each: read data for Rs and Rt.
REQ-011 The block SHALL have the ports WB_data (output, 32 bits), WB_we (output, 1 bit) and WB_rd (output, 5 bits): the effective writeback data, enable and destination, for the forwarding unit.

Function
REQ-012 The block SHALL hold 32 registers of 32 bits each, with register 0 always reading 0.
REQ-013 The block SHALL compute WB_data combinationally: Data_in when MemtoReg_in=1, else ALUShift_out_in.
REQ-014 The block SHALL compute WB_we = RegWr_in AND NOT Overflow_in AND (Rd_in != 0) AND (Rd_write_by_en_in != 0).
REQ-015 The block SHALL set WB_rd equal to Rd_in.
REQ-016 At each rising clk edge with Reset=0 and WB_we=1, the block SHALL update only the enabled bytes of register Rd_in with the corresponding bytes of WB_data and SHALL leave the disabled bytes unchanged.
REQ-017 The block SHALL ignore every write to register 0; Rd_in=0 with RegWr_in=1 SHALL have no effect.
REQ-018 When Overflow_in=1, the block SHALL suppress the entire write regardless of the byte enables (trapping add/sub).
REQ-019 The block SHALL drive busA and busB combinationally from the array contents at Rs_addr and Rt_addr.
REQ-020 When WB_we=1 and a read address equals Rd_in (non-zero), the block SHALL return the byte-merged value on that read port (enabled bytes from WB_data, other bytes from the array), so that a read in the same cycle as the write sees the new value without waiting for the edge.
REQ-021 The block SHALL apply the REQ-020 bypass independently per port, and SHALL apply it to both ports when Rs_addr equals Rt_addr.
REQ-022 Reads of address 0 SHALL return 0 even when a bypass condition would otherwise apply.
REQ-023 The block SHALL have a latency of 0 cycles from input to bus (bypass) and SHALL make the update visible in the array after 1 rising edge.

Reset
REQ-024 When Reset=1 at a rising clk edge, the block SHALL clear all 32 registers to 0, and any concurrent write SHALL be discarded.
REQ-025 While Reset=1, busA and busB SHALL read the array contents with the bypass disabled, and WB_we SHALL be forced to 0.
REQ-026 After Reset deasserts, the first rising edge SHALL accept writes normally.
REQ-027 The block SHALL never clear the array outside Reset.

Verification
REQ-028 The bench SHALL cover: Reset pulse for 1 edge, then read all 32 addresses -> every read returns 0x00000000.
REQ-029 The bench SHALL cover: RegWr=1, MemtoReg=0, ALUShift_out=0xDEADBEEF, en=4'hF, Rd=5, Rs_addr=5 -> busA=0xDEADBEEF before the edge (bypass) and after the edge (array).
REQ-030 The bench SHALL cover: starting from R5=0xDEADBEEF, MemtoReg=1, Data=0x11223344, en=4'b0011 -> R5 becomes 0xDEAD3344; with Rs=Rt=5, both buses show 0xDEAD3344 in the write cycle.
REQ-031 The bench SHALL cover: Overflow=1, RegWr=1, Rd=7, en=4'hF, ALUShift_out=0x7FFFFFFF -> WB_we=0 and R7 unchanged at 0.
REQ-032 The bench SHALL cover: RegWr=1, Rd=0, data=0xFFFFFFFF -> WB_we=0 and a read of address 0 returns 0.
REQ-033 The bench SHALL cover: Reset=1 coincident with a write of 0x12345678 to R9 -> R9=0 after the edge, and busA (Rs=9) reads 0 during reset.
